// File: rtl/cnt_addsub_pipe.sv
// Counter-selected add/subtract datapath with a two-stage valid pipeline and overflow flag.
// Define CNT_ADDSUB_SAT_EN to saturate results instead of wrapping them.
module cnt_addsub_pipe #(
   parameter int DW = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          cnt_clr,
   input  logic [CW-1:0] match_val,
   input  logic          in_valid,
   input  logic [DW-1:0] dina,
   input  logic [DW-1:0] dinb,
   output logic          out_valid,
   output logic [DW-1:0] dout,
   output logic          op_add,
   output logic          ovf,
   output logic [CW-1:0] cnt
);

   logic          v1;
   logic [DW-1:0] a1;
   logic [DW-1:0] b1;
   logic          sel1;

   logic [DW:0]   sum_w;
   logic [DW:0]   diff_w;
   logic [DW-1:0] res_w;
   logic          ovf_w;

   // Event counter; a clear takes priority over an increment.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Stage 1 captures operands and the select, compared against the pre-update count.
   // NOTE: datapath registers are reset too, so outputs are defined before the first sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         sel1 <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            a1   <= dina;
            b1   <= dinb;
            sel1 <= (cnt == match_val);
         end
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      sum_w  = {1'b0, a1} + {1'b0, b1};
      diff_w = {1'b0, a1} - {1'b0, b1};
      res_w  = '0;
      ovf_w  = 1'b0;
      if (sel1) begin
         ovf_w = sum_w[DW];
`ifdef CNT_ADDSUB_SAT_EN
         res_w = sum_w[DW] ? {DW{1'b1}} : sum_w[DW-1:0];
`else
         res_w = sum_w[DW-1:0];
`endif
      end else begin
         ovf_w = (a1 < b1);
`ifdef CNT_ADDSUB_SAT_EN
         res_w = (a1 < b1) ? {DW{1'b0}} : diff_w[DW-1:0];
`else
         res_w = diff_w[DW-1:0];
`endif
      end
   end

   // Stage 2 presents the result; result fields hold during valid gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         dout      <= '0;
         op_add    <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            dout   <= res_w;
            op_add <= sel1;
            ovf    <= ovf_w;
         end
      end
   end

endmodule

// File: tb/tb_cnt_addsub_pipe.sv
// Scoreboard bench for cnt_addsub_pipe (DW=16, CW=8): directed vectors with hand-computed results.
// Expected saturation values follow CNT_ADDSUB_SAT_EN when the bench is built with it.
module tb_cnt_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [7:0]  match_val = '0;
   logic        in_valid = 1'b0;
   logic [15:0] dina = '0;
   logic [15:0] dinb = '0;
   logic        out_valid;
   logic [15:0] dout;
   logic        op_add;
   logic        ovf;
   logic [7:0]  cnt;

   typedef struct {
      logic [15:0] d;
      logic        add;
      logic        ov;
      int          at;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [7:0]  m_cnt = '0;

`ifdef CNT_ADDSUB_SAT_EN
   localparam logic [15:0] E_ADD_OV  = 16'hFFFF;
   localparam logic [15:0] E_SUB_UN  = 16'h0000;
   localparam logic [15:0] E_ADD_OV2 = 16'hFFFF;
   localparam logic [15:0] E_SUB_UN2 = 16'h0000;
`else
   localparam logic [15:0] E_ADD_OV  = 16'h0010;
   localparam logic [15:0] E_SUB_UN  = 16'hFFFC;
   localparam logic [15:0] E_ADD_OV2 = 16'h0000;
   localparam logic [15:0] E_SUB_UN2 = 16'hFFFF;
`endif

   cnt_addsub_pipe #(.DW(16), .CW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cnt_clr   (cnt_clr),
      .match_val (match_val),
      .in_valid  (in_valid),
      .dina      (dina),
      .dinb      (dinb),
      .out_valid (out_valid),
      .dout      (dout),
      .op_add    (op_add),
      .ovf       (ovf),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on out_valid, otherwise checks the held outputs.
   initial begin
      logic [15:0] last_d;
      logic        last_add;
      logic        last_ov;
      exp_t        e;
      last_d = '0;
      last_add = 1'b0;
      last_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("out_valid_in_reset", out_valid, 0);
            last_d = '0;
            last_add = 1'b0;
            last_ov = 1'b0;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               check("out_valid_unexpected", out_valid, 0);
            end else begin
               e = sb.pop_front();
               check("dout", dout, e.d);
               check("op_add", op_add, e.add);
               check("ovf", ovf, e.ov);
               check("latency_cycle", cyc, e.at);
               last_d = e.d;
               last_add = e.add;
               last_ov = e.ov;
            end
         end else begin
            check("hold_dout", dout, last_d);
            check("hold_op_add", op_add, last_add);
            check("hold_ovf", ovf, last_ov);
         end
      end
   end

   // One cycle of stimulus, driven at a falling edge; returns at the next falling edge.
   task automatic drive(input logic v, input logic e, input logic c, input logic [7:0] mv,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic eadd, input logic eov);
      en = e;
      cnt_clr = c;
      match_val = mv;
      in_valid = v;
      dina = a;
      dinb = b;
      if (v) sb.push_back(exp_t'{ed, eadd, eov, cyc + 2});
      if (c) m_cnt = '0;
      else if (e) m_cnt = m_cnt + 8'd1;
      @(negedge clk);
      check("cnt", cnt, m_cnt);
   endtask

   task automatic idle(input int n, input logic e, input logic [7:0] mv);
      for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, mv, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic check_idle();
      check("idle_cnt", cnt, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_dout", dout, 0);
      check("idle_op_add", op_add, 0);
      check("idle_ovf", ovf, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      // Reset and idle.
      repeat (3) begin
         @(negedge clk);
         check_idle();
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_idle();
      end

      // Match select: ADD only for the sample taken at cnt=144.
      idle(142, 1'b1, 8'd144);
      drive(1'b1, 1'b1, 1'b0, 8'd144, 16'd1000, 16'd300, 16'd700,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd144, 16'd1000, 16'd300, 16'd700,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd144, 16'd1000, 16'd300, 16'd1300, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd144, 16'd1000, 16'd300, 16'd700,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd144, 16'd1000, 16'd300, 16'd700,  1'b0, 1'b0);

      // Overflow / underflow with the counter held at 0.
      drive(1'b0, 1'b0, 1'b1, 8'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 16'hFFF0, 16'h0020, E_ADD_OV,  1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd1, 16'd5,    16'd9,    E_SUB_UN,  1'b0, 1'b1);
      idle(3, 1'b0, 8'd1);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'h0001, E_ADD_OV2, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'h0000, 16'hFFFF,  1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd1, 16'd7,    16'd7,    16'h0000,  1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd1, 16'd0,    16'd1,    E_SUB_UN2, 1'b0, 1'b1);

      // Counter wrap: match_val=0 selects ADD again after 255 -> 0.
      idle(253, 1'b1, 8'd0);
      drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd10, 16'd3, 16'd7,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd10, 16'd3, 16'd7,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd10, 16'd3, 16'd7,  1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd10, 16'd3, 16'd13, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd10, 16'd3, 16'd7,  1'b0, 1'b0);
      // Clear with enable at cnt=77: the sample still sees 77, the counter goes to 0.
      idle(75, 1'b1, 8'd77);
      drive(1'b1, 1'b1, 1'b1, 8'd77, 16'd20, 16'd5, 16'd25, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd77, 16'd20, 16'd5, 16'd15, 1'b0, 1'b0);
      idle(3, 1'b0, 8'd0);

      // Reset mid-pipe: two accepted samples must never emerge.
      en = 1'b1;
      cnt_clr = 1'b0;
      match_val = 8'd0;
      in_valid = 1'b1;
      dina = 16'd100;
      dinb = 16'd1;
      @(negedge clk);
      dina = 16'd200;
      dinb = 16'd2;
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      en = 1'b0;
      sb.delete();
      m_cnt = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3, 1'b0, 8'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd2, 16'd3, 16'd5, 1'b1, 1'b0);
      idle(4, 1'b0, 8'd0);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
